// File: rtl/decoder38.sv
// Registered N-to-2**N line decoder with enable and selectable output polarity.
// All outputs come straight from flops so downstream enables see no decode glitches.
module decoder38 #(
  parameter  int IN_WIDTH       = 3,
  parameter  bit ACTIVE_LOW_OUT = 1'b0,
  localparam int OutWidth       = 2 ** IN_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [IN_WIDTH-1:0] data_in,
  output logic [OutWidth-1:0] data_out
);

  logic [OutWidth-1:0] w_oneHot;
  logic [OutWidth-1:0] w_nextOut;
  logic [OutWidth-1:0] w_idleOut;
  logic [OutWidth-1:0] r_dataOut;

  assign w_idleOut = {OutWidth{ACTIVE_LOW_OUT}};

  always_comb begin
    w_oneHot = '0;
    if (enable) begin
      w_oneHot[data_in] = 1'b1;
    end
  end

  // Inverting the whole word flips both the selected bit and the idle bits.
  assign w_nextOut = ACTIVE_LOW_OUT ? ~w_oneHot : w_oneHot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dataOut <= w_idleOut;
    end else begin
      r_dataOut <= w_nextOut;
    end
  end

  assign data_out = r_dataOut;

endmodule

// File: tb/tb_decoder38.sv
// Self-checking bench for decoder38: drives both polarities from one vector table
// plus directed reset sequences.
module tb_decoder38;

  typedef struct {
    logic       en;
    logic [2:0] din;
    logic [7:0] exp;
  } vec_t;

  logic       clk;
  logic       rstN;
  logic       enable;
  logic [2:0] dataIn;
  logic [7:0] outHigh;
  logic [7:0] outLow;

  int total;
  int bad;

  decoder38 #(.IN_WIDTH(3), .ACTIVE_LOW_OUT(1'b0)) dutHigh (
    .clk      (clk),
    .rst_n    (rstN),
    .enable   (enable),
    .data_in  (dataIn),
    .data_out (outHigh)
  );

  decoder38 #(.IN_WIDTH(3), .ACTIVE_LOW_OUT(1'b1)) dutLow (
    .clk      (clk),
    .rst_n    (rstN),
    .enable   (enable),
    .data_in  (dataIn),
    .data_out (outLow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", name, actual, expected);
    end
  endtask

  // Drives one input pair, lets one edge sample it, then checks both polarities.
  task automatic applyStimulus(input string name, input logic en, input logic [2:0] din,
                               input logic [7:0] exp);
    enable = en;
    dataIn = din;
    @(posedge clk);
    #1;
    checkOutput({name, "_hi"}, outHigh, exp);
    checkOutput({name, "_lo"}, outLow, ~exp);
  endtask

  vec_t vecs[$];

  initial begin
    total  = 0;
    bad    = 0;
    rstN   = 1'b0;
    enable = 1'b1;
    dataIn = 3'b101;

    for (int i = 0; i < 8; i++) vecs.push_back('{1'b0, 3'(i), 8'h00});
    for (int i = 0; i < 8; i++) vecs.push_back('{1'b1, 3'(i), 8'h01 << i});
    vecs.push_back('{1'b1, 3'b011, 8'h08});
    vecs.push_back('{1'b0, 3'b011, 8'h00});
    vecs.push_back('{1'b1, 3'b011, 8'h08});
    vecs.push_back('{1'b0, 3'b110, 8'h00});
    vecs.push_back('{1'b1, 3'b010, 8'h04});
    vecs.push_back('{1'b1, 3'b111, 8'h80});
    vecs.push_back('{1'b1, 3'b000, 8'h01});

    // Reset held with an active select must keep outputs idle.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checkOutput("reset_hold_hi", outHigh, 8'h00);
      checkOutput("reset_hold_lo", outLow, 8'hFF);
    end

    rstN = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_release_hi", outHigh, 8'h20);
    checkOutput("reset_release_lo", outLow, 8'hDF);

    foreach (vecs[i]) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].en, vecs[i].din, vecs[i].exp);
    end

    // Asynchronous clear between edges, then recovery on the first edge.
    applyStimulus("pre_reset", 1'b1, 3'b111, 8'h80);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("async_clear_hi", outHigh, 8'h00);
    checkOutput("async_clear_lo", outLow, 8'hFF);
    @(posedge clk);
    #1;
    checkOutput("async_hold_hi", outHigh, 8'h00);
    dataIn = 3'b000;
    rstN   = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("async_release_hi", outHigh, 8'h01);
    checkOutput("async_release_lo", outLow, 8'hFE);

    // Mid-cycle input changes must not reach the outputs before the next edge.
    enable = 1'b1;
    dataIn = 3'b100;
    #2;
    checkOutput("no_comb_path_hi", outHigh, 8'h01);
    @(posedge clk);
    #1;
    checkOutput("after_edge_hi", outHigh, 8'h10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
